alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue and hazard controller sitting in front of the ALU, between decode and execute. It inserts bubbles, squashes instructions on redirect and drives the ALU's `need_forward`/`forward` bypass inputs. It tracks two in-flight stages (EX1 = issued last cycle, WB = issued two cycles ago) and sequences register-file writeback. The ALU has a single forward bus, so the block stalls whenever one bus cannot serve both operands.

## Interface
- XLEN, 32, datapath width
- BUBBLE_OP, 12'b000000010011, operation issued on a bubble (addi x0,x0,0)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high
- id_valid  input  1  decode slot holds an instruction
- id_operation  input  12  funct+opcode; [6:0] = opcode
- id_rs1, id_rs2, id_rd  input  5 each  register indices
- flush  input  1  redirect; squash current decode slot
- alu_rd  input  XLEN  ALU registered result (EX1 instruction's result)
- mem_rdata  input  XLEN  load data, valid in the load's WB cycle
- alu_operation  output  12  operation to ALU (id_operation or BUBBLE_OP)
- need_forward  output  2  bit1 = rs1 from `forward`, bit0 = rs2 from `forward`
- forward  output  XLEN  bypass value
- stall  output  1  hold decode slot this cycle
- wb_we  output  1  register-file write enable
- wb_addr  output  5  write index
- wb_data  output  XLEN  write data

## Operation
- Writer opcodes are 0110011, 0010011, 0000011 (load), 1101111, 1100111, 0010111, 0110111. A writer with rd = 0 counts as a non-writer.
- Operand usage:
  - R (0110011) and B (1100011) use rs1 and rs2.
  - 0010011, 0000011 and 0100011 use rs1 only.
  - All other opcodes use neither.
  - Store data is out of scope.
- State:
  - EX1 = {valid, rd, writes, is_load}.
  - WB = {valid, rd, writes, is_load, alu_val}.
  - Every edge: WB ← EX1, with alu_val ← alu_rd. EX1 ← issued slot.
  - The issued slot is a bubble (valid = 0) when !id_valid, stall or flush.
- Hazard match: a used source with index ≠ 0 equals EX1.rd (EX1 valid and writes), or else equals WB.rd (WB valid and writes). EX1 has priority.
- Source value:
  - EX1 match gives alu_rd.
  - WB match gives mem_rdata if WB.is_load, otherwise WB.alu_val.
- Stall when id_valid && !flush and either condition holds:
  - load-use: a used source matches EX1 and EX1.is_load;
  - bus conflict: rs1 and rs2 both match with rs1 ≠ rs2.
- Forward when not stalled:
  - need_forward[1] = rs1 matched, need_forward[0] = rs2 matched.
  - forward = value of the matched source.
  - rs1 = rs2 with both matched gives 2'b11.
- alu_operation:
  - id_operation when id_valid && !stall && !flush.
  - Otherwise BUBBLE_OP, with need_forward = 0 and forward = 0.
- Writeback:
  - wb_we = WB.valid && WB.writes.
  - wb_addr = WB.rd.
  - wb_data = mem_rdata if WB.is_load, otherwise WB.alu_val.
- The register file reads old data on a same-cycle write. The WB bypass covers that case.

## Timing
- stall, need_forward, forward, alu_operation and wb_* are combinational from inputs and state. There are no registered outputs.
- Issue-to-writeback latency is 2 cycles. A result is forwardable in its EX1 cycle (non-load only) and its WB cycle.
- A stall always clears in 1 cycle:
  - Load-use: the load reaches WB with mem_rdata valid.
  - Bus conflict: the WB producer retires and at most one match remains.
- Decode must hold id_* stable while stall = 1.
- flush together with a stall condition: flush wins; stall = 0, bubble issued.
- flush does not kill EX1 or WB; older instructions complete.
- Reset (asynchronous, any cycle, including mid-stall):
  - EX1.valid = WB.valid = 0.
  - Outputs immediately: wb_we = 0, wb_addr = 0, wb_data = 0, stall = 0, need_forward = 0, forward = 0, alu_operation = BUBBLE_OP (id_valid is low in reset).
- First issue is possible on the first edge after reset deasserts.

## Test plan
- Back-to-back dependency: add x5 (alu_rd = 0x10), then add x6,x5,x7 next cycle gives need_forward = 2'b10, forward = 0x10, stall = 0. Two cycles later: wb_we = 1, wb_addr = 6.
- Load-use: lw x3, then addi x4,x3,1 gives stall = 1 and alu_operation = BUBBLE_OP for 1 cycle. Next cycle: need_forward = 2'b10, forward = mem_rdata (0xCAFE), wb_addr = 3.
- Bus conflict: add x1 (0x5) then add x2 (0x7) issued back to back, then add x3,x1,x2. Result: 1 stall cycle, then need_forward = 2'b01 with forward = 0x7 (x1 already written).
- Same source: add x8 (0x9) then add x9,x8,x8 gives need_forward = 2'b11, forward = 0x9, no stall.
- x0 and non-writers: add x0 then add x1,x0,x0 gives need_forward = 0. A store or branch followed by a dependent read gives no forward and wb_we = 0.
- Flush and reset: a stall condition with flush = 1 gives stall = 0 and BUBBLE_OP; the squashed instruction is never written back. Reset asserted mid-stall gives wb_we = 0 and stall = 0 immediately.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issue/hazard control in front of the ALU: bubbles, forwarding, writeback
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   id_valid, id_operation,          decode slot: valid, funct+opcode ([6:0] = opcode),
//   id_rs1, id_rs2, id_rd            source and destination register indices
//   flush                            squash the current decode slot
//   alu_rd                           ALU registered result of the EX1 instruction
//   mem_rdata                        load data, valid in the load's WB cycle
//   alu_operation                    operation to the ALU (id_operation or BUBBLE_OP)
//   need_forward, forward            bypass select {rs1, rs2} and bypass value
//   stall                            hold the decode slot this cycle
//   wb_we, wb_addr, wb_data          register-file write port
module alu_issue_ctrl #(
    parameter int          XLEN      = 32,
    parameter logic [11:0] BUBBLE_OP = 12'b000000010011
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [11:0]     id_operation,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            flush,
    input  logic [XLEN-1:0] alu_rd,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [11:0]     alu_operation,
    output logic [1:0]      need_forward,
    output logic [XLEN-1:0] forward,
    output logic            stall,
    output logic            wb_we,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // EX1 stage (issued last cycle)
    logic            ex1_valid_q, ex1_valid_d;
    logic [4:0]      ex1_rd_q, ex1_rd_d;
    logic            ex1_writes_q, ex1_writes_d;
    logic            ex1_is_load_q, ex1_is_load_d;
    // WB stage (issued two cycles ago)
    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_writes_q, wb_writes_d;
    logic            wb_is_load_q, wb_is_load_d;
    logic [XLEN-1:0] wb_alu_val_q, wb_alu_val_d;

    logic [6:0]      opcode;
    logic            id_writes, id_is_load, uses_rs1, uses_rs2;
    logic            rs1_ex1, rs1_wb, rs2_ex1, rs2_wb;
    logic            rs1_match, rs2_match;
    logic [XLEN-1:0] wb_value, rs1_value, rs2_value;
    logic            load_use, bus_conflict, issue;

    // Decode classification
    always_comb begin
        opcode     = id_operation[6:0];
        id_is_load = (opcode == OP_LOAD);
        id_writes  = 1'b0;
        case (opcode)
            OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: id_writes = (id_rd != 5'd0);
            default: id_writes = 1'b0;
        endcase
        uses_rs1 = (opcode == OP_R) || (opcode == OP_BRANCH) || (opcode == OP_IMM) ||
                   (opcode == OP_LOAD) || (opcode == OP_STORE);
        uses_rs2 = (opcode == OP_R) || (opcode == OP_BRANCH);
    end

    // Hazard detection; EX1 has priority over WB since it holds the newer value
    always_comb begin
        rs1_ex1 = uses_rs1 && (id_rs1 != 5'd0) && ex1_valid_q && ex1_writes_q && (id_rs1 == ex1_rd_q);
        rs2_ex1 = uses_rs2 && (id_rs2 != 5'd0) && ex1_valid_q && ex1_writes_q && (id_rs2 == ex1_rd_q);
        rs1_wb  = uses_rs1 && (id_rs1 != 5'd0) && !rs1_ex1 && wb_valid_q && wb_writes_q && (id_rs1 == wb_rd_q);
        rs2_wb  = uses_rs2 && (id_rs2 != 5'd0) && !rs2_ex1 && wb_valid_q && wb_writes_q && (id_rs2 == wb_rd_q);
        rs1_match = rs1_ex1 || rs1_wb;
        rs2_match = rs2_ex1 || rs2_wb;

        wb_value  = wb_is_load_q ? mem_rdata : wb_alu_val_q;
        rs1_value = rs1_ex1 ? alu_rd : wb_value;
        rs2_value = rs2_ex1 ? alu_rd : wb_value;

        // Load data only exists in the WB cycle, so an EX1 load match must wait one cycle
        load_use     = (rs1_ex1 || rs2_ex1) && ex1_is_load_q;
        // One forward bus: two matched, distinct sources cannot both be served
        bus_conflict = rs1_match && rs2_match && (id_rs1 != id_rs2);

        stall = id_valid && !flush && (load_use || bus_conflict);
        issue = id_valid && !flush && !stall;
    end

    // Issue outputs
    always_comb begin
        alu_operation = BUBBLE_OP;
        need_forward  = 2'b00;
        forward       = '0;
        if (issue) begin
            alu_operation = id_operation;
            need_forward  = {rs1_match, rs2_match};
            if (rs1_match)
                forward = rs1_value;
            else if (rs2_match)
                forward = rs2_value;
        end
    end

    // Writeback port straight from the WB stage
    always_comb begin
        wb_we   = wb_valid_q && wb_writes_q;
        wb_addr = wb_rd_q;
        wb_data = wb_value;
    end

    // Pipeline advance
    always_comb begin
        ex1_valid_d   = issue;
        ex1_rd_d      = id_rd;
        ex1_writes_d  = id_writes;
        ex1_is_load_d = id_is_load;
        wb_valid_d    = ex1_valid_q;
        wb_rd_d       = ex1_rd_q;
        wb_writes_d   = ex1_writes_q;
        wb_is_load_d  = ex1_is_load_q;
        wb_alu_val_d  = alu_rd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex1_valid_q   <= 1'b0;
            ex1_rd_q      <= 5'd0;
            ex1_writes_q  <= 1'b0;
            ex1_is_load_q <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_writes_q   <= 1'b0;
            wb_is_load_q  <= 1'b0;
            wb_alu_val_q  <= '0;
        end else begin
            ex1_valid_q   <= ex1_valid_d;
            ex1_rd_q      <= ex1_rd_d;
            ex1_writes_q  <= ex1_writes_d;
            ex1_is_load_q <= ex1_is_load_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_writes_q   <= wb_writes_d;
            wb_is_load_q  <= wb_is_load_d;
            wb_alu_val_q  <= wb_alu_val_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

    localparam logic [11:0] BUBBLE = 12'h013;
    localparam logic [11:0] ADD    = 12'h033;
    localparam logic [11:0] ADDI   = 12'h093;
    localparam logic [11:0] LW     = 12'h103;
    localparam logic [11:0] SW     = 12'h123;
    localparam logic [11:0] BEQ    = 12'h063;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [11:0] id_operation;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        flush;
    logic [31:0] alu_rd, mem_rdata;
    logic [11:0] alu_operation;
    logic [1:0]  need_forward;
    logic [31:0] forward;
    logic        stall;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_operation(id_operation),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .alu_rd(alu_rd), .mem_rdata(mem_rdata), .alu_operation(alu_operation),
        .need_forward(need_forward), .forward(forward), .stall(stall),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [11:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd);
        id_valid = v; id_operation = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, ADD, 5'd0, 5'd0, 5'd0);
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; alu_rd = '0; mem_rdata = '0;
        drive(1'b0, ADD, 5'd0, 5'd0, 5'd0);
        #12;
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_nf", 32'(need_forward), 32'd0);
        check("rst_fwd", forward, 32'd0);
        check("rst_op", 32'(alu_operation), 32'(BUBBLE));
        next_cycle();
        reset = 1'b0;

        // Back-to-back dependency
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd5); #1;
        check("b2b_first_op", 32'(alu_operation), 32'(ADD));
        check("b2b_first_nf", 32'(need_forward), 32'd0);
        next_cycle();
        drive(1'b1, ADD, 5'd5, 5'd7, 5'd6); alu_rd = 32'h10; #1;
        check("b2b_nf", 32'(need_forward), 32'd2);
        check("b2b_fwd", forward, 32'h10);
        check("b2b_stall", 32'(stall), 32'd0);
        next_cycle();
        drive(1'b0, ADD, 5'd0, 5'd0, 5'd0); alu_rd = 32'h20; #1;
        check("b2b_wb5_addr", 32'(wb_addr), 32'd5);
        check("b2b_wb5_data", wb_data, 32'h10);
        next_cycle();
        check("b2b_wb6_we", 32'(wb_we), 32'd1);
        check("b2b_wb6_addr", 32'(wb_addr), 32'd6);
        check("b2b_wb6_data", wb_data, 32'h20);
        idle(2);

        // Load-use
        drive(1'b1, LW, 5'd10, 5'd0, 5'd3); #1;
        check("lu_load_stall", 32'(stall), 32'd0);
        next_cycle();
        drive(1'b1, ADDI, 5'd3, 5'd0, 5'd4); #1;
        check("lu_stall", 32'(stall), 32'd1);
        check("lu_op", 32'(alu_operation), 32'(BUBBLE));
        check("lu_nf_stalled", 32'(need_forward), 32'd0);
        next_cycle();
        mem_rdata = 32'hCAFE; #1;
        check("lu_release", 32'(stall), 32'd0);
        check("lu_nf", 32'(need_forward), 32'd2);
        check("lu_fwd", forward, 32'hCAFE);
        check("lu_op_issue", 32'(alu_operation), 32'(ADDI));
        check("lu_wb_addr", 32'(wb_addr), 32'd3);
        check("lu_wb_data", wb_data, 32'hCAFE);
        idle(3);

        // Bus conflict
        drive(1'b1, ADD, 5'd0, 5'd0, 5'd1);
        next_cycle();
        drive(1'b1, ADD, 5'd0, 5'd0, 5'd2); alu_rd = 32'h5;
        next_cycle();
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd3); alu_rd = 32'h7; #1;
        check("bc_stall", 32'(stall), 32'd1);
        check("bc_op", 32'(alu_operation), 32'(BUBBLE));
        check("bc_wb1_addr", 32'(wb_addr), 32'd1);
        check("bc_wb1_data", wb_data, 32'h5);
        next_cycle();
        check("bc_release", 32'(stall), 32'd0);
        check("bc_nf", 32'(need_forward), 32'd1);
        check("bc_fwd", forward, 32'h7);
        idle(3);

        // Same source on both operands
        drive(1'b1, ADD, 5'd0, 5'd0, 5'd8);
        next_cycle();
        drive(1'b1, ADD, 5'd8, 5'd8, 5'd9); alu_rd = 32'h9; #1;
        check("ss_nf", 32'(need_forward), 32'd3);
        check("ss_fwd", forward, 32'h9);
        check("ss_stall", 32'(stall), 32'd0);
        idle(3);

        // x0 destination
        drive(1'b1, ADD, 5'd0, 5'd0, 5'd0);
        next_cycle();
        drive(1'b1, ADD, 5'd0, 5'd0, 5'd1); alu_rd = 32'h33; #1;
        check("x0_nf", 32'(need_forward), 32'd0);
        next_cycle();
        drive(1'b0, ADD, 5'd0, 5'd0, 5'd0); #1;
        check("x0_wb_we", 32'(wb_we), 32'd0);
        idle(2);

        // Store then dependent read
        drive(1'b1, SW, 5'd0, 5'd0, 5'd5);
        next_cycle();
        drive(1'b1, ADD, 5'd5, 5'd5, 5'd6); #1;
        check("st_nf", 32'(need_forward), 32'd0);
        next_cycle();
        drive(1'b0, ADD, 5'd0, 5'd0, 5'd0); #1;
        check("st_wb_we", 32'(wb_we), 32'd0);
        idle(2);

        // Branch then dependent read
        drive(1'b1, BEQ, 5'd0, 5'd0, 5'd7);
        next_cycle();
        drive(1'b1, ADDI, 5'd7, 5'd0, 5'd1); #1;
        check("br_nf", 32'(need_forward), 32'd0);
        check("br_stall", 32'(stall), 32'd0);
        idle(3);

        // Flush beats load-use stall
        drive(1'b1, LW, 5'd0, 5'd0, 5'd3);
        next_cycle();
        drive(1'b1, ADDI, 5'd3, 5'd0, 5'd4); flush = 1'b1; #1;
        check("fl_stall", 32'(stall), 32'd0);
        check("fl_op", 32'(alu_operation), 32'(BUBBLE));
        check("fl_nf", 32'(need_forward), 32'd0);
        next_cycle();
        flush = 1'b0; drive(1'b0, ADD, 5'd0, 5'd0, 5'd0); #1;
        check("fl_load_wb_we", 32'(wb_we), 32'd1);
        check("fl_load_wb_addr", 32'(wb_addr), 32'd3);
        next_cycle();
        check("fl_squashed_wb_we", 32'(wb_we), 32'd0);
        idle(2);

        // Reset asserted mid-stall
        drive(1'b1, ADD, 5'd0, 5'd0, 5'd10);
        next_cycle();
        drive(1'b1, LW, 5'd0, 5'd0, 5'd3); alu_rd = 32'h44;
        next_cycle();
        drive(1'b1, ADDI, 5'd3, 5'd0, 5'd4); #1;
        check("rs_pre_stall", 32'(stall), 32'd1);
        check("rs_pre_wb_we", 32'(wb_we), 32'd1);
        #1 reset = 1'b1; #1;
        check("rs_stall", 32'(stall), 32'd0);
        check("rs_wb_we", 32'(wb_we), 32'd0);
        check("rs_wb_addr", 32'(wb_addr), 32'd0);
        check("rs_wb_data", wb_data, 32'd0);
        check("rs_nf", 32'(need_forward), 32'd0);
        drive(1'b0, ADD, 5'd0, 5'd0, 5'd0); #1;
        check("rs_op", 32'(alu_operation), 32'(BUBBLE));
        next_cycle();
        reset = 1'b0;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
